// File: rtl/img_mem_pkg.sv
// Shared constants for the image memory arbiter: default widths,
// requester tags carried down the read pipeline, and arbitration modes.
package img_mem_pkg;

    localparam int ADDR_WIDTH_DEF = 19;
    localparam int DATA_WIDTH_DEF = 8;

    // Tag identifying which requester owns an access in flight
    localparam logic TAG_C = 1'b0;
    localparam logic TAG_U = 1'b1;

    // Arbitration policy selectors
    localparam int PRIO_RR      = 0;
    localparam int PRIO_FIXED_C = 1;

endpackage

// File: rtl/img_mem_arbiter_rr_arb2.sv
// Two-way arbiter between the processor (C) and the UART (U).
// Grants are combinational; the last-grant pointer is the only state.
module rr_arb2
    import img_mem_pkg::*;
#(
    parameter int PRIO_MODE = PRIO_RR
) (
    input  logic clk,
    input  logic rst,
    input  logic c_req_i,
    input  logic u_req_i,
    output logic c_gnt_o,
    output logic u_gnt_o
);

    logic last_q;
    logic last_d;
    logic c_wins_tie;

    // Decide the winner: C wins a tie under fixed priority or when U went last
    always_comb begin
        c_wins_tie = (PRIO_MODE == PRIO_FIXED_C) || (last_q == TAG_U);
        c_gnt_o    = c_req_i && (!u_req_i || c_wins_tie);
        u_gnt_o    = u_req_i && !c_gnt_o;
        last_d     = last_q;
        if (c_gnt_o) begin
            last_d = TAG_C;
        end else if (u_gnt_o) begin
            last_d = TAG_U;
        end
    end

    // Remember who was granted last; reset points at U so C takes the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= TAG_U;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/img_mem_arbiter.sv
// Shares one single-port synchronous image RAM (1-cycle read latency)
// between the processor and the UART loader. Accepted accesses are
// registered onto the RAM port; read tags follow a two-stage pipeline
// so the returning data is steered to the port that asked for it.
module img_mem_arbiter
    import img_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRIO_MODE  = PRIO_RR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    output logic                  c_gnt,
    output logic                  c_rvalid,
    output logic [DATA_WIDTH-1:0] c_rdata,
    input  logic                  u_req,
    input  logic                  u_we,
    input  logic [ADDR_WIDTH-1:0] u_addr,
    input  logic [DATA_WIDTH-1:0] u_wdata,
    output logic                  u_gnt,
    output logic                  u_rvalid,
    output logic [DATA_WIDTH-1:0] u_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  busy
);

    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_re_q, mem_re_d;
    logic                  s1_tag_q, s1_tag_d;
    logic                  s2_rd_q;
    logic                  s2_tag_q;
    logic                  c_rvalid_q, u_rvalid_q;
    logic [DATA_WIDTH-1:0] c_rdata_q, u_rdata_q;

    rr_arb2 #(
        .PRIO_MODE (PRIO_MODE)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .c_req_i (c_req),
        .u_req_i (u_req),
        .c_gnt_o (c_gnt),
        .u_gnt_o (u_gnt)
    );

    // Select the winner's access; with no grant the strobes drop and the address holds
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        s1_tag_d    = s1_tag_q;
        if (c_gnt) begin
            mem_addr_d  = c_addr;
            mem_wdata_d = c_wdata;
            mem_we_d    = c_we;
            mem_re_d    = !c_we;
            s1_tag_d    = TAG_C;
        end else if (u_gnt) begin
            mem_addr_d  = u_addr;
            mem_wdata_d = u_wdata;
            mem_we_d    = u_we;
            mem_re_d    = !u_we;
            s1_tag_d    = TAG_U;
        end
    end

    // Register the RAM port and stage 1 (mem_re doubles as the stage-1 read valid)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            s1_tag_q    <= TAG_C;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            s1_tag_q    <= s1_tag_d;
        end
    end

    // Stage 2 marks the cycle in which mem_q carries the read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_rd_q  <= 1'b0;
            s2_tag_q <= TAG_C;
        end else begin
            s2_rd_q  <= mem_re_q;
            s2_tag_q <= s1_tag_q;
        end
    end

    // Steer returning data to the tagged port; rdata holds between pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_rvalid_q <= 1'b0;
            u_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            u_rdata_q  <= '0;
        end else begin
            c_rvalid_q <= s2_rd_q && (s2_tag_q == TAG_C);
            u_rvalid_q <= s2_rd_q && (s2_tag_q == TAG_U);
            if (s2_rd_q && (s2_tag_q == TAG_C)) begin
                c_rdata_q <= mem_q;
            end
            if (s2_rd_q && (s2_tag_q == TAG_U)) begin
                u_rdata_q <= mem_q;
            end
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign c_rvalid  = c_rvalid_q;
    assign u_rvalid  = u_rvalid_q;
    assign c_rdata   = c_rdata_q;
    assign u_rdata   = u_rdata_q;
    assign busy      = mem_re_q | mem_we_q | s2_rd_q;

endmodule

// File: doc/img_mem_arbiter.md
Name: img_mem_arbiter

Overview:
- Shares one single-port synchronous image RAM (1-cycle read latency) between two requesters: the processor (port C) and the UART loader/dumper (port U).
- Each requester gets a req/gnt handshake and a tagged read-return path.
- Sits between processor/UART_FSM and the image memory instance inside top_mod. It replaces the current dual-port dependency, so the image RAM can be mapped to single-port block RAM.

Parameters:
- ADDR_WIDTH, 19, image address width (both requesters and RAM).
- DATA_WIDTH, 8, pixel data width.
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority to port C.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- c_req  in  1  processor access request
- c_we  in  1  1 = write, 0 = read
- c_addr  in  ADDR_WIDTH  processor address
- c_wdata  in  DATA_WIDTH  processor write data
- c_gnt  out  1  request accepted this cycle (combinational)
- c_rvalid  out  1  read data valid on c_rdata
- c_rdata  out  DATA_WIDTH  read return data
- u_req, u_we, u_addr, u_wdata, u_gnt, u_rvalid, u_rdata: same as the c_ ports, for the UART side
- mem_addr  out  ADDR_WIDTH  registered RAM address
- mem_we  out  1  registered RAM write enable
- mem_re  out  1  registered RAM read enable
- mem_wdata  out  DATA_WIDTH  registered RAM write data
- mem_q  in  DATA_WIDTH  RAM read data, valid 1 cycle after mem_re
- busy  out  1  access in flight (mem_re/mem_we high or a read pending return)

Behaviour:
- Reset values (async): mem_addr 0, mem_we 0, mem_re 0, mem_wdata 0, c_rvalid 0, u_rvalid 0, c_rdata 0, u_rdata 0, busy 0, last-grant pointer = U (so C wins the first tie).
- Grant logic:
  - At most one grant per cycle; c_gnt and u_gnt are never both 1.
  - gnt is combinational from req and the pointer.
  - Only C requesting -> c_gnt. Only U requesting -> u_gnt.
  - Both requesting, PRIO_MODE=0: grant the port not granted last. PRIO_MODE=1: always C.
  - Pointer updates only on a grant.
- Handshake:
  - A requester holds req/we/addr/wdata stable until it sees gnt high at a rising edge.
  - The access is accepted on that edge. The requester may then drop req or present the next access; back-to-back grants are allowed every cycle.
- Pipeline (request accepted at edge N):
  - Edge N: mem_addr/mem_we/mem_re/mem_wdata register the winner's values; the requester tag is pushed into stage 1.
  - Cycle N+1: RAM sees the access.
  - Edge N+1: stage 1 moves to stage 2.
  - Edge N+2: for a read, the tagged port's rdata <= mem_q and rvalid <= 1 for exactly one cycle.
- Read latency: gnt edge to rvalid = 2 cycles. Writes produce no rvalid.
- No grant -> mem_we = mem_re = 0 on the next edge. mem_addr holds its last value.
- rdata holds its value between rvalid pulses.
- Write followed by read of the same address on consecutive grants: the read returns the new data (RAM read-after-write in a later cycle).
- Read return of one port never asserts the other port's rvalid. Interleaved C/U reads return in grant order.
- busy = mem_re | mem_we | stage-2 read pending.
- Reset mid-operation: in-flight reads are dropped and no rvalid follows. The pointer returns to U.
- req with we=1 and we=0 are treated identically for arbitration.
- Address/data are not range-checked and are passed through at full width.

Decomposition:
- Package img_mem_pkg: ADDR_WIDTH/DATA_WIDTH defaults, requester tag constants (TAG_C=0, TAG_U=1), PRIO_MODE encodings.
- One natural sub-module, rr_arb2: the 2-way round-robin/fixed-priority arbiter holding the pointer.
- The pipeline and return demux stay in img_mem_arbiter.

Test Plan:
- Only c_req=1, we=0, addr=0x00010; mem_q returns 0xA5 -> c_gnt same cycle, mem_re=1 at N+1, c_rvalid=1 with c_rdata=0xA5 at N+2, u_rvalid stays 0.
- Both ports hold req continuously for 6 cycles, PRIO_MODE=0 -> grants alternate C,U,C,U,C,U starting with C after reset.
- Same stimulus with PRIO_MODE=1 -> c_gnt all 6 cycles, u_gnt 0 throughout; u granted on the first cycle c_req=0.
- U writes 0x3C to 0x7FFFF, then C reads 0x7FFFF next cycle -> c_rdata=0x3C, mem_addr=0x7FFFF (full 19-bit).
- C read granted, rst asserted the next cycle for 1 cycle -> all outputs 0 immediately, no c_rvalid pulse afterward, busy=0.
- Back-to-back reads C@1, U@2, C@3 with RAM returning 0x11/0x22/0x33 -> c_rvalid, u_rvalid, c_rvalid on consecutive cycles carrying 0x11, 0x22, 0x33.
